// File: rtl/sdp_ram_pipe_if.sv
// Bus bundle for sdp_ram_pipe: write port, read port, snapshot control and status.
// The slave modport is the RAM side; the master modport is the datapath driving it.
interface sdp_ram_pipe_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 7
);
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr_in;
  logic [DATA_W-1:0]     d;
  logic                  re;
  logic [ADDR_W-1:0]     addr_out;
  logic [DATA_W-1:0]     q;
  logic                  q_valid;
  logic                  cap_en;
  logic [DATA_W-1:0]     B;
  logic                  oor;

  modport master (
    output we, be, addr_in, d, re, addr_out, cap_en,
    input  q, q_valid, B, oor
  );

  modport slave (
    input  we, be, addr_in, d, re, addr_out, cap_en,
    output q, q_valid, B, oor
  );
endinterface

// File: rtl/sdp_ram_pipe.sv
// Simple dual-port RAM with byte-enabled writes, a tracked read pipeline, an optional
// output register, selectable read-during-write behaviour and a snapshot register.
module sdp_ram_pipe #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned OUT_REG  = 0,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic        clk1,
  input  logic        reset,
  sdp_ram_pipe_if.slave bus
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  generate
    if ((DATA_W % 8) != 0 || DATA_W == 0) begin : gen_bad_data_w
      $error("sdp_ram_pipe: DATA_W must be a non-zero multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : gen_bad_depth
      $error("sdp_ram_pipe: DEPTH must lie in 1 .. 2**ADDR_W");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] rd_addr_r;
  logic              rd_v1;
  logic [DATA_W-1:0] s1_q;
  logic              s1_v;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              req_oor;
  logic              rd_collide;
  logic [IdxW-1:0]   wr_idx;
  logic [IdxW-1:0]   rd_idx;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    wr_in_range = ({1'b0, bus.addr_in} < DepthW);
    rd_in_range = ({1'b0, rd_addr_r} < DepthW);
    wr_idx      = bus.addr_in[IdxW-1:0];
    rd_idx      = rd_addr_r[IdxW-1:0];
    // Both out-of-range writes and out-of-range read requests make the flag stick.
    req_oor     = (bus.we && !wr_in_range) ||
                  (bus.re && ({1'b0, bus.addr_out} >= DepthW));
    rd_collide  = bus.we && wr_in_range && rd_in_range && (bus.addr_in == rd_addr_r);
  end

  // Storage is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clk1) begin
    if (bus.we && wr_in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.be[i]) begin
          mem[wr_idx][8*i +: 8] <= bus.d[8*i +: 8];
        end
      end
    end
  end

  // The array read sees the pre-write word; new-data mode patches in the enabled bytes.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_idx];
    end
    if ((RDW_MODE != 0) && rd_collide) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.be[i]) begin
          rd_word[8*i +: 8] = bus.d[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      rd_addr_r   <= '0;
      rd_v1       <= 1'b0;
      s1_q        <= '0;
      s1_v        <= 1'b0;
      bus.q       <= '0;
      bus.q_valid <= 1'b0;
      bus.B       <= '0;
      bus.oor     <= 1'b0;
    end else begin
      if (bus.re) begin
        rd_addr_r <= bus.addr_out;
      end
      rd_v1 <= bus.re;

      if (rd_v1) begin
        s1_q <= rd_word;
      end
      s1_v <= rd_v1;

      // q only moves on a completed read, so idle slots leave the last data visible.
      if (OUT_REG != 0) begin
        if (s1_v) begin
          bus.q <= s1_q;
        end
        bus.q_valid <= s1_v;
      end else begin
        if (rd_v1) begin
          bus.q <= rd_word;
        end
        bus.q_valid <= rd_v1;
      end

      if (bus.cap_en) begin
        bus.B <= bus.q;
      end

      if (req_oor) begin
        bus.oor <= 1'b1;
      end
    end
  end

endmodule
